// File: rtl/cordic_angle_arbiter_if.sv
// ----------------------------------------------------------------------------
// cordic_angle_arbiter_if
// Requester-facing bundle of the CORDIC angle arbiter.
//   req_valid  : per-requester request valid
//   req_x/req_y: packed operands, requester i at [i*DSIZE +: DSIZE]
//   req_mask   : per-requester arbitration enable
//   req_ready  : one-hot (or zero) grant back to the requesters
//   res_valid  : one-hot result strobe
//   res_id     : requester ID of the current result
//   res_angle  : full-turn result angle, 2^(ASIZE+2) per turn
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface cordic_angle_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DSIZE = 16,
    parameter int ASIZE = 16
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_x;
    logic [NREQ*DSIZE-1:0] req_y;
    logic [NREQ-1:0]       req_mask;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       res_valid;
    logic [IDW-1:0]        res_id;
    logic [ASIZE+1:0]      res_angle;

    modport master (
        output req_valid, req_x, req_y, req_mask,
        input  req_ready, res_valid, res_id, res_angle
    );

    modport slave (
        input  req_valid, req_x, req_y, req_mask,
        output req_ready, res_valid, res_id, res_angle
    );
endinterface

// File: rtl/cordic_angle_arbiter.sv
// ----------------------------------------------------------------------------
// cordic_angle_arbiter
// Round-robin scheduler sharing one pipelined X/Y-to-angle CORDIC core among
// NREQ requesters. One operand pair is issued per cycle; a tag delay line
// matched to the core latency routes each returned angle back to its issuer.
// A RUN/DRAIN/HALT state machine lets the core be quiesced.
//
// Optional feature macro: CORDIC_ARB_QUADRANT_EN
//   defined   : operands are two's complement, the core sees |X|/|Y| and the
//               sign quadrant travels with the tag to unfold a full-turn angle.
//   undefined : operands pass through unsigned, res_angle = {2'b00, c_angle}.
//
// Ports:
//   clock     : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : requester/result bundle (slave modport)
//   halt_req  : stop issuing and drain the core
//   halted    : core empty and arbiter in HALT
//   cx, cy    : registered operands to the core
//   c_angle   : core output angle (first quadrant, 2^ASIZE = 90 degrees)
//   busy      : at least one operation in flight
// ----------------------------------------------------------------------------
module cordic_angle_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int DSIZE      = 16,
    parameter int ASIZE      = 16,
    parameter int CORDIC_LAT = 8
) (
    input  logic                   clock,
    input  logic                   rst_n,
    cordic_angle_arbiter_if.slave  bus,
    input  logic                   halt_req,
    output logic                   halted,
    output logic [DSIZE-1:0]       cx,
    output logic [DSIZE-1:0]       cy,
    input  logic [ASIZE-1:0]       c_angle,
    output logic                   busy
);

    localparam int AW = ASIZE + 2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef CORDIC_ARB_QUADRANT_EN
    // Magnitude of a two's-complement value; the most negative value maps to
    // 2^(DSIZE-1), which is representable as unsigned.
    function automatic logic [DSIZE-1:0] abs_val(input logic [DSIZE-1:0] v);
        return v[DSIZE-1] ? (~v + DSIZE'(1)) : v;
    endfunction
`endif

    // Unfold a first-quadrant angle into the full turn using the sign
    // quadrant {x_neg, y_neg}; arithmetic wraps modulo 2^(ASIZE+2).
    function automatic logic [AW-1:0] fold_angle(input logic [ASIZE-1:0] a,
                                                 input logic [1:0]       q);
        logic [AW-1:0] ext;
        logic [AW-1:0] two_f;
        ext   = {2'b00, a};
        two_f = {2'b10, {ASIZE{1'b0}}};
        case (q)
            2'b00:   return ext;
            2'b10:   return two_f - ext;
            2'b11:   return two_f + ext;
            2'b01:   return {AW{1'b0}} - ext;
            default: return ext;
        endcase
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [IDW-1:0]        ptr_r;
    logic [NREQ-1:0]       elig_s;
    logic [2*NREQ-1:0]     elig2_s;
    logic [NREQ-1:0]       rot_s;
    logic [IDW-1:0]        off_s;
    logic [IDW:0]          sum_s;
    logic [IDW-1:0]        gid_s;
    logic                  accept_s;
    logic [NREQ-1:0]       grant_s;
    logic [DSIZE-1:0]      sel_x_s;
    logic [DSIZE-1:0]      sel_y_s;
    logic [DSIZE-1:0]      op_x_s;
    logic [DSIZE-1:0]      op_y_s;
    logic [1:0]            quad_s;
    logic                  busy_s;
    logic [DSIZE-1:0]      cx_r;
    logic [DSIZE-1:0]      cy_r;
    logic [CORDIC_LAT:0]   tag_v_r;
    logic [IDW-1:0]        tag_id_r [0:CORDIC_LAT];
    logic [1:0]            tag_q_r  [0:CORDIC_LAT];
    logic [NREQ-1:0]       res_valid_r;
    logic [IDW-1:0]        res_id_r;
    logic [AW-1:0]         res_angle_r;

    // Eligibility, rotated so bit 0 is the requester at the round-robin pointer.
    always_comb begin
        elig_s  = bus.req_valid & bus.req_mask & {NREQ{state_r == ST_RUN}};
        elig2_s = {elig_s, elig_s} >> ptr_r;
        rot_s   = elig2_s[NREQ-1:0];
    end

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        off_s = {IDW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IDW'(k) : off_s;
        end
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= NREQ_W) begin
            gid_s = IDW'(sum_s - NREQ_W);
        end else begin
            gid_s = sum_s[IDW-1:0];
        end
    end

    // Grant vector and operand selection for the winning requester.
    always_comb begin
        accept_s = |rot_s;
        grant_s  = accept_s ? (ONE_HOT0 << gid_s) : {NREQ{1'b0}};
        sel_x_s  = bus.req_x[gid_s*DSIZE +: DSIZE];
        sel_y_s  = bus.req_y[gid_s*DSIZE +: DSIZE];
`ifdef CORDIC_ARB_QUADRANT_EN
        op_x_s   = abs_val(sel_x_s);
        op_y_s   = abs_val(sel_y_s);
        quad_s   = {sel_x_s[DSIZE-1], sel_y_s[DSIZE-1]};
`else
        op_x_s   = sel_x_s;
        op_y_s   = sel_y_s;
        quad_s   = 2'b00;
`endif
    end

    // Halt/drain next-state logic.
    always_comb begin
        busy_s      = |tag_v_r;
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_nxt_s = ST_RUN;
                end else if (!busy_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register and round-robin pointer (advances past the granted index).
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            ptr_r   <= {IDW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ptr_r <= (gid_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gid_s + IDW'(1);
            end
        end
    end

    // Core operand registers; they hold when nothing is accepted.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cx_r <= {DSIZE{1'b0}};
            cy_r <= {DSIZE{1'b0}};
        end else if (accept_s) begin
            cx_r <= op_x_s;
            cy_r <= op_y_s;
        end
    end

    // Tag delay line, one stage longer than the core so the tag lines up with
    // the cycle in which c_angle is sampled.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            tag_v_r <= {(CORDIC_LAT+1){1'b0}};
            for (int s = 0; s <= CORDIC_LAT; s++) begin
                tag_id_r[s] <= {IDW{1'b0}};
                tag_q_r[s]  <= 2'b00;
            end
        end else begin
            tag_v_r     <= {tag_v_r[CORDIC_LAT-1:0], accept_s};
            tag_id_r[0] <= accept_s ? gid_s : {IDW{1'b0}};
            tag_q_r[0]  <= accept_s ? quad_s : 2'b00;
            for (int s = 1; s <= CORDIC_LAT; s++) begin
                tag_id_r[s] <= tag_id_r[s-1];
                tag_q_r[s]  <= tag_q_r[s-1];
            end
        end
    end

    // Result capture from the last tag stage and the core output.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            res_valid_r <= {NREQ{1'b0}};
            res_id_r    <= {IDW{1'b0}};
            res_angle_r <= {AW{1'b0}};
        end else begin
            res_valid_r <= tag_v_r[CORDIC_LAT] ? (ONE_HOT0 << tag_id_r[CORDIC_LAT])
                                               : {NREQ{1'b0}};
            res_id_r    <= tag_id_r[CORDIC_LAT];
            res_angle_r <= fold_angle(c_angle, tag_q_r[CORDIC_LAT]);
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_angle = res_angle_r;
    assign cx            = cx_r;
    assign cy            = cy_r;
    assign busy          = busy_s;
    assign halted        = (state_r == ST_HALT);

endmodule

// File: tb/tb_cordic_angle_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cordic_angle_arbiter
// Directed bench for cordic_angle_arbiter. A stub core returns a simple,
// hand-predictable angle CORDIC_LAT cycles after cx/cy:
//   cy == 0 -> 0, cx == 0 -> 16'hFFFF (90 degrees saturated),
//   cx == cy -> 16'h8000 (45 degrees), otherwise cx ^ cy.
// Expected results are pushed into a bench delay line at each expected accept
// and compared against the result strobe CORDIC_LAT+1 edges later.
// ----------------------------------------------------------------------------
module tb_cordic_angle_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DSIZE = 16;
    localparam int ASIZE = 16;
    localparam int LAT   = 8;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              halt_req = 1'b0;
    logic              halted;
    logic [DSIZE-1:0]  cx;
    logic [DSIZE-1:0]  cy;
    logic [ASIZE-1:0]  c_angle;
    logic              busy;

    int total = 0;
    int bad   = 0;

    cordic_angle_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    cordic_angle_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DSIZE(DSIZE), .ASIZE(ASIZE), .CORDIC_LAT(LAT)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .bus      (bus),
        .halt_req (halt_req),
        .halted   (halted),
        .cx       (cx),
        .cy       (cy),
        .c_angle  (c_angle),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] core_f(input logic [15:0] x, input logic [15:0] y);
        if (y == 16'd0)      return 16'h0000;
        else if (x == 16'd0) return 16'hFFFF;
        else if (x == y)     return 16'h8000;
        else                 return x ^ y;
    endfunction

    // Stub core pipeline.
    logic [15:0] core_pipe [0:LAT-1];
    always @(posedge clock) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) core_pipe[s] <= 16'h0000;
        end else begin
            core_pipe[0] <= core_f(cx, cy);
            for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
        end
    end
    assign c_angle = core_pipe[LAT-1];

    // Expected-result delay line.
    logic        exp_in_v   = 1'b0;
    logic [1:0]  exp_in_id  = 2'd0;
    logic [17:0] exp_in_ang = 18'd0;
    logic        exp_v_p   [0:LAT+1];
    logic [1:0]  exp_id_p  [0:LAT+1];
    logic [17:0] exp_ang_p [0:LAT+1];
    always @(posedge clock) begin
        if (!rst_n) begin
            for (int s = 0; s <= LAT + 1; s++) exp_v_p[s] <= 1'b0;
        end else begin
            exp_v_p[0]   <= exp_in_v;
            exp_id_p[0]  <= exp_in_id;
            exp_ang_p[0] <= exp_in_ang;
            for (int s = 1; s <= LAT + 1; s++) begin
                exp_v_p[s]   <= exp_v_p[s-1];
                exp_id_p[s]  <= exp_id_p[s-1];
                exp_ang_p[s] <= exp_ang_p[s-1];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
        bus.req_x[i*DSIZE +: DSIZE] = x;
        bus.req_y[i*DSIZE +: DSIZE] = y;
    endtask

    // One cycle: check the combinational grant, register the expected accept,
    // take the edge, then check the result strobe against the delay line.
    task automatic step(input string tag, input logic [3:0] exp_grant, input logic [17:0] eang);
        logic [1:0] eid;
        logic [3:0] exp_rv;
        eid = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (exp_grant[i]) eid = 2'(i);
        end
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_grant));
        exp_in_v   = |exp_grant;
        exp_in_id  = eid;
        exp_in_ang = eang;
        @(posedge clock);
        #1;
        exp_rv = exp_v_p[LAT+1] ? (4'b0001 << exp_id_p[LAT+1]) : 4'b0000;
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'(exp_rv));
        if (exp_v_p[LAT+1]) begin
            check({tag, "_res_id"}, 32'(bus.res_id), 32'(exp_id_p[LAT+1]));
            check({tag, "_res_angle"}, 32'(bus.res_angle), 32'(exp_ang_p[LAT+1]));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_id"},    32'(bus.res_id),    32'd0);
        check({tag, "_res_angle"}, 32'(bus.res_angle), 32'd0);
        check({tag, "_cx"},        32'(cx),            32'd0);
        check({tag, "_cy"},        32'(cy),            32'd0);
        check({tag, "_halted"},    32'(halted),        32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
    endtask

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_mask  = 4'b1111;
        bus.req_x     = {(NREQ*DSIZE){1'b0}};
        bus.req_y     = {(NREQ*DSIZE){1'b0}};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Reset mid-flight: accept requester 2, reset two cycles later.
        set_req(2, 16'd100, 16'd0);
        bus.req_valid = 4'b0100;
        step("mid_acc", 4'b0100, 18'h00000);
        check("mid_cx", 32'(cx), 32'd100);
        check("mid_busy", 32'(busy), 32'd1);
        bus.req_valid = 4'b0000;
        step("mid_gap", 4'b0000, 18'h00000);
        rst_n = 1'b0;
        step("mid_rst", 4'b0000, 18'h00000);
        check_zero_outputs("mid_rst");
        rst_n = 1'b1;
        for (int n = 0; n < LAT + 3; n++) step("mid_flush", 4'b0000, 18'h00000);

        // Fairness: all valid, all enabled, grants 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NREQ; i++) set_req(i, 16'h0100 + 16'(i), 16'h0011);
        bus.req_valid = 4'b1111;
        step("rr0", 4'b0001, 18'h00111);
        check("rr0_cx", 32'(cx), 32'h0100);
        check("rr0_cy", 32'(cy), 32'h0011);
        step("rr1", 4'b0010, 18'h00110);
        step("rr2", 4'b0100, 18'h00113);
        step("rr3", 4'b1000, 18'h00112);
        step("rr4", 4'b0001, 18'h00111);
        step("rr5", 4'b0010, 18'h00110);
        step("rr6", 4'b0100, 18'h00113);
        step("rr7", 4'b1000, 18'h00112);

        // Masking: only requesters 1 and 3 may win.
        bus.req_mask = 4'b1010;
        step("mk0", 4'b0010, 18'h00110);
        step("mk1", 4'b1000, 18'h00112);
        step("mk2", 4'b0010, 18'h00110);
        step("mk3", 4'b1000, 18'h00112);

        // Halt/drain with three operations in flight.
        bus.req_mask  = 4'b1111;
        bus.req_valid = 4'b0111;
        step("h0", 4'b0001, 18'h00111);
        step("h1", 4'b0010, 18'h00110);
        step("h2", 4'b0100, 18'h00113);
        bus.req_valid = 4'b0000;
        halt_req = 1'b1;
        step("h3", 4'b0000, 18'h00000);
        check("h3_halted", 32'(halted), 32'd0);
        check("h3_busy", 32'(busy), 32'd1);
        bus.req_valid = 4'b1111;
        for (int m = 1; m <= LAT + 2; m++) begin
            step("hd", 4'b0000, 18'h00000);
            check("hd_busy", 32'(busy), 32'(m < LAT));
            check("hd_halted", 32'(halted), 32'(m >= LAT + 1));
        end
        halt_req = 1'b0;
        step("hr0", 4'b0000, 18'h00000);
        check("hr0_halted", 32'(halted), 32'd0);
        step("hr1", 4'b1000, 18'h00112);
        step("hr2", 4'b0001, 18'h00111);
        bus.req_valid = 4'b0000;
        for (int n = 0; n < LAT + 3; n++) step("h_flush", 4'b0000, 18'h00000);

        // Quadrant handling; requester 0 alone is granted every cycle.
        bus.req_valid = 4'b0001;
`ifdef CORDIC_ARB_QUADRANT_EN
        set_req(0, 16'hFC18, 16'h0000);
        step("q_negx", 4'b0001, 18'h20000);
        check("q_negx_cx", 32'(cx), 32'h03E8);
        check("q_negx_cy", 32'(cy), 32'h0000);
        set_req(0, 16'h0000, 16'hFC18);
        step("q_negy", 4'b0001, 18'h30001);
        check("q_negy_cy", 32'(cy), 32'h03E8);
        set_req(0, 16'h03E8, 16'h03E8);
        step("q_diag", 4'b0001, 18'h08000);
        set_req(0, 16'hFC18, 16'hFC18);
        step("q_negxy", 4'b0001, 18'h28000);
        set_req(0, 16'h8000, 16'h0005);
        step("q_min", 4'b0001, 18'h17FFB);
        check("q_min_cx", 32'(cx), 32'h8000);
        check("q_min_cy", 32'(cy), 32'h0005);
`else
        set_req(0, 16'h8000, 16'h0000);
        step("p_8000", 4'b0001, 18'h00000);
        check("p_8000_cx", 32'(cx), 32'h8000);
        check("p_8000_cy", 32'(cy), 32'h0000);
        set_req(0, 16'h1234, 16'h0F0F);
        step("p_xor", 4'b0001, 18'h01D3B);
        check("p_xor_cy", 32'(cy), 32'h0F0F);
        set_req(0, 16'h8000, 16'h8000);
        step("p_diag", 4'b0001, 18'h08000);
`endif
        bus.req_valid = 4'b0000;
        for (int n = 0; n < LAT + 3; n++) step("q_flush", 4'b0000, 18'h00000);
        check("end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_angle_arbiter.md
# cordic_angle_arbiter

Round-robin scheduler sharing one pipelined `X_Y_to_angle` CORDIC core among NREQ requesters. Accepts at most one (X,Y) pair per cycle and drives it into the core. A tag delay line matched to the core latency routes each returned angle to the issuing requester. A halt/drain state machine allows the core to be quiesced. Optional quadrant folding extends the first-quadrant core to full-circle angles.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester-ID width; 2^IDW >= NREQ.
- `DSIZE`, 16: X/Y width.
- `ASIZE`, 16: core angle width; full scale is 90°.
- `CORDIC_LAT`, 8: core latency in clocks, from a registered `cx/cy` change to a valid `c_angle`; must be >= 1.
- `clock` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_x` in NREQ*DSIZE: packed X; requester i occupies bits [i*DSIZE +: DSIZE].
- `req_y` in NREQ*DSIZE: packed Y, same packing as `req_x`.
- `req_ready` out NREQ: grant, one-hot or zero, combinational.
- `req_mask` in NREQ: 1 enables requester i for arbitration.
- `halt_req` in 1: request to stop issuing and drain the core.
- `halted` out 1: core empty and arbiter in HALT.
- `cx`, `cy` out DSIZE: registered operands to the core.
- `c_angle` in ASIZE: core output angle.
- `res_valid` out NREQ: one-hot result strobe, registered.
- `res_id` out IDW: requester ID of the current result.
- `res_angle` out ASIZE+2: result angle, full turn = 2^(ASIZE+2).
- `busy` out 1: at least one operation is in flight.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i] & req_mask[i]` and state is RUN.
- **Grant:** goes to the first eligible index at or after pointer `ptr`, wrapping. `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Accept:** an accept is `req_valid[i] & req_ready[i]`. On accept:
  - `cx/cy` load the operands.
  - A tag {1, i, quad} enters stage 0 of a CORDIC_LAT+1 deep shift register.
  - `ptr` becomes (i+1) mod NREQ.
  - With no grant, `ptr` holds and a tag {0,x,x} enters; `cx/cy` hold.
- **Result capture:** when the tag reaches the last stage, the block registers:
  - `res_valid` = onehot(id) if the tag is valid, otherwise 0.
  - `res_id` = id.
  - `res_angle` from `c_angle` and the tag quadrant.
- **busy:** OR of all tag valid bits.
- **State machine:**
  - RUN: if `halt_req` = 1, go to DRAIN.
  - DRAIN: no grants. If `halt_req` = 0, go to RUN. Otherwise, if `busy` = 0, go to HALT.
  - HALT: no grants; `halted` = 1. If `halt_req` = 0, go to RUN.
- **Changes during DRAIN/HALT:** `req_mask` may change at any time; it takes effect on the next arbitration.
- **Reset:** `rst_n` = 0 at an edge clears the following; in-flight results are discarded and never strobed:
  - state to RUN, `ptr` to 0, all tags invalid.
  - `cx`, `cy`, `res_valid`, `res_id`, `res_angle` to 0.
  - `halted` to 0.

## Timing
- Accept at edge k: `cx/cy` are valid after edge k, and `res_valid` is high for exactly the cycle after edge k+CORDIC_LAT+1.
- Throughput is one accept per cycle; back-to-back accepts from different requesters are allowed.
- Results return in issue order. Results never stall; consumers must take them.
- `halt_req` sampled 1 at edge k blocks any grant in cycle k+1.
- After the last accept at edge j, `halted` is high after edge max(k, j+CORDIC_LAT+2).
- If a single requester is eligible, it is granted every cycle.

## Configuration
- **`CORDIC_ARB_QUADRANT_EN` defined:**
  - `req_x/req_y` are two's complement. `cx`/`cy` = |X|/|Y| as unsigned DSIZE; |−2^(DSIZE−1)| = 2^(DSIZE−1).
  - quad = {X<0, Y<0} travels with the tag. With a = `c_angle` and F = 2^ASIZE, `res_angle` (mod 2^(ASIZE+2)) is:
    - quad 00: a.
    - quad 10: 2F − a.
    - quad 11: 2F + a.
    - quad 01: 4F − a.
- **Undefined:** inputs are unsigned and pass through unchanged, quad = 00, and `res_angle` = {2'b00, `c_angle`}.

## Test plan
- **Reset mid-flight:** reset, then accept requester 2 with X=100, Y=0, and assert `rst_n` = 0 two cycles later → `res_valid` is never asserted, and all outputs are 0 one edge after reset.
- **Fairness:** all four requesters hold `req_valid` continuously with mask 4'b1111 → grant order 0,1,2,3,0,… with one grant per cycle; results return in the same order exactly CORDIC_LAT+1 edges after each accept.
- **Masking:** mask 4'b1010 with all valid → grants alternate 1,3 only; requesters 0 and 2 never see `req_ready`.
- **Halt/drain:** `halt_req` = 1 while three operations are in flight → no further grants, `busy` falls once the last result strobes, `halted` = 1 the next cycle; dropping `halt_req` restores grants the cycle after.
- **Quadrant folding (macro on):** X=−1000, Y=0 → `res_angle` = 2F; X=0, Y=−1000 → 3F; X=1000, Y=1000 → F/2 ± CORDIC error tolerance (2^(ASIZE−RNUM)).
- **Quadrant folding (macro off):** X=0x8000, Y=0 → `cx` = 0x8000, `res_angle` = 0.
